tlul_source_tracker: RTL and testbench
======================================

# tlul_source_tracker

In-line monitor/gate on a TL-UL host port that tracks every outstanding A-channel request by source ID and retires it on the matching D-channel response. It sits directly downstream of the bus parameter set: all channel field widths come from the bus parameters (source, size). It throttles the host's A-channel ready when its table is full. It flags protocol violations: duplicate source, response to unknown source, opcode or size mismatch. Used both in RTL shims and as a synthesizable checker inside DV harnesses.

## Interface
- BUS_AIW, 8, source ID width.
- BUS_SZW, 2, transfer size field width.
- MaxOut, 4, table depth (maximum outstanding requests), legal 1..16.
- CntW, $clog2(MaxOut+1), outstanding counter width (derived; do not override).

Ports (all channel inputs are the raw wires of the observed port):
- clk_i  in  1  clock; everything is on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- a_valid_i  in  1  host A-channel valid.
- a_ready_i  in  1  device A-channel ready.
- a_opcode_i  in  3  A opcode: 0 PutFull, 1 PutPartial, 4 Get; others illegal.
- a_size_i  in  BUS_SZW  A size.
- a_source_i  in  BUS_AIW  A source ID.
- a_ready_o  out  1  gated ready to host: a_ready_i & ~full_o.
- d_valid_i  in  1  device D-channel valid.
- d_ready_i  in  1  host D-channel ready.
- d_opcode_i  in  3  D opcode: 0 AccessAck, 1 AccessAckData.
- d_size_i  in  BUS_SZW  D size.
- d_source_i  in  BUS_AIW  D source ID.
- outstanding_o  out  CntW  number of valid table entries.
- full_o / empty_o  out  1  outstanding_o == MaxOut / == 0.
- err_a_o  out  1  one-cycle pulse: A-side error (duplicate source or illegal opcode).
- err_d_o  out  1  one-cycle pulse: D-side error.
- err_d_code_o  out  2  1 unknown source, 2 opcode mismatch, 3 size mismatch; 0 otherwise.
- err_source_o  out  BUS_AIW  source of the most recent error.

## Operation
- Each table entry holds: valid, source, expected D opcode (Get→1, Put*→0), size.
- A handshake is a_valid_i & a_ready_o. D handshake is d_valid_i & d_ready_i.
- On an A handshake:
  - If a_source_i matches a valid entry that is not being retired this cycle: err_a_o is raised and nothing is allocated.
  - If a_opcode_i is illegal: err_a_o is raised and nothing is allocated.
  - Otherwise the lowest-index free entry is written.
- On a D handshake, entries are looked up by d_source_i:
  - No match: code 1, no state change.
  - Match with wrong opcode: code 2.
  - Match with wrong size: code 3. Opcode mismatch takes priority over size mismatch.
  - A matched entry is always freed, even when an error is flagged.
- Same cycle A and D:
  - The D retire and the A allocate both take effect.
  - An A reusing the source being retired in that cycle is legal.
  - The allocation may reuse the freed index only in a later cycle. The free search uses registered valid bits minus nothing, so while full the same-cycle slot is not available.
- outstanding_o += alloc − retire each cycle. It never wraps: allocation is impossible when full, and retire is impossible when empty.
- When both err_a_o and err_d_o fire, err_source_o takes the D source.
- Table contents are never exposed; only counts and errors are visible.

## Timing
- a_ready_o is combinational from a_ready_i and registered full_o. No other combinational in→out path exists.
- Table state, outstanding_o, full_o and empty_o update on the clock edge of the handshake.
- err_* outputs are registered: they pulse exactly one cycle, in the cycle after the offending handshake.
- Reset values: all entries invalid, outstanding_o=0, full_o=0, empty_o=1, err_a_o=0, err_d_o=0, err_d_code_o=0, err_source_o=0.
- A reset asserted mid-operation discards all entries. Responses arriving after reset report code 1.
- While full, a_ready_o=0. A D retire on edge N drops full_o at N, so a_ready_o can reassert in cycle N+1.

## Test plan
- Get with source 0x05, size 2, then AccessAckData with source 0x05, size 2 → outstanding_o goes 1 then 0; no error pulses.
- Issue 4 Puts with sources 1..4 (MaxOut=4) → full_o=1 and a_ready_o=0 even with a_ready_i=1. Retire source 3 → a_ready_o=1 in the next cycle.
- Put on source 7 while 7 is outstanding → err_a_o pulses one cycle later; outstanding_o unchanged.
- D with source 0x22 and nothing outstanding → err_d_o=1, err_d_code_o=1, err_source_o=0x22; counts unchanged.
- Get on source 9, then AccessAck (opcode 0) with source 9 → code 2 and the entry is freed. Put size 2 answered with size 1 → code 3.
- Same cycle: D retires source 6 while A issues a Put on source 6 → no err_a_o, and outstanding_o is unchanged. Assert rst_i with 3 entries outstanding → next cycle outstanding_o=0, empty_o=1.

Source files
------------

// File: rtl/tlul_source_tracker.sv
// TL-UL outstanding-request tracker: one table entry per in-flight source,
// A-side allocation/duplicate checks, D-side retire/mismatch checks.
module tlul_source_tracker_entry #(
    parameter int BUS_AIW = 8,
    parameter int BUS_SZW = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               alloc,
    input  logic               free,
    input  logic [BUS_AIW-1:0] wr_src,
    input  logic               wr_op,
    input  logic [BUS_SZW-1:0] wr_size,
    output logic               vld,
    output logic [BUS_AIW-1:0] src,
    output logic               op,
    output logic [BUS_SZW-1:0] size
);
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld  <= 1'b0;
            src  <= '0;
            op   <= 1'b0;
            size <= '0;
        end else if (alloc) begin
            vld  <= 1'b1;
            src  <= wr_src;
            op   <= wr_op;
            size <= wr_size;
        end else if (free) begin
            vld <= 1'b0;
        end
    end
endmodule

module tlul_source_tracker #(
    parameter int BUS_AIW = 8,
    parameter int BUS_SZW = 2,
    parameter int MaxOut  = 4,
    parameter int CntW    = $clog2(MaxOut + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               a_valid_i,
    input  logic               a_ready_i,
    input  logic [2:0]         a_opcode_i,
    input  logic [BUS_SZW-1:0] a_size_i,
    input  logic [BUS_AIW-1:0] a_source_i,
    output logic               a_ready_o,
    input  logic               d_valid_i,
    input  logic               d_ready_i,
    input  logic [2:0]         d_opcode_i,
    input  logic [BUS_SZW-1:0] d_size_i,
    input  logic [BUS_AIW-1:0] d_source_i,
    output logic [CntW-1:0]    outstanding_o,
    output logic               full_o,
    output logic               empty_o,
    output logic               err_a_o,
    output logic               err_d_o,
    output logic [1:0]         err_d_code_o,
    output logic [BUS_AIW-1:0] err_source_o
);
    logic [MaxOut-1:0]              ent_vld, ent_op, alloc_vec, free_vec;
    logic [MaxOut-1:0][BUS_AIW-1:0] ent_src;
    logic [MaxOut-1:0][BUS_SZW-1:0] ent_size;

    logic a_hs, d_hs, a_legal, a_dup, d_hit, alloc, retire;
    logic [1:0] d_code;

    assign a_ready_o = a_ready_i & ~full_o;
    assign a_hs      = a_valid_i & a_ready_o;
    assign d_hs      = d_valid_i & d_ready_i;
    assign a_legal   = (a_opcode_i == 3'd0) || (a_opcode_i == 3'd1) || (a_opcode_i == 3'd4);

    always_comb begin
        d_hit     = 1'b0;
        d_code    = 2'd0;
        free_vec  = '0;
        a_dup     = 1'b0;
        alloc_vec = '0;
        // D lookup first so a same-cycle retire of the A source is not a duplicate
        for (int i = 0; i < MaxOut; i++) begin
            if (!d_hit && ent_vld[i] && ent_src[i] == d_source_i) begin
                d_hit = 1'b1;
                free_vec[i] = d_hs;
                if (d_opcode_i != {2'b00, ent_op[i]})
                    d_code = 2'd2;
                else if (d_size_i != ent_size[i])
                    d_code = 2'd3;
            end
        end
        if (!d_hit) d_code = 2'd1;
        for (int i = 0; i < MaxOut; i++)
            if (ent_vld[i] && ent_src[i] == a_source_i && !free_vec[i]) a_dup = 1'b1;
        // Lowest free index from registered valids only
        for (int i = MaxOut - 1; i >= 0; i--)
            if (!ent_vld[i]) alloc_vec = MaxOut'(1) << i;
        if (!(a_hs && a_legal && !a_dup)) alloc_vec = '0;
    end

    assign alloc  = |alloc_vec;
    assign retire = |free_vec;

    for (genvar g = 0; g < MaxOut; g++) begin : g_ent
        tlul_source_tracker_entry #(.BUS_AIW(BUS_AIW), .BUS_SZW(BUS_SZW)) u_ent (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .alloc  (alloc_vec[g]),
            .free   (free_vec[g]),
            .wr_src (a_source_i),
            .wr_op  (a_opcode_i == 3'd4),
            .wr_size(a_size_i),
            .vld    (ent_vld[g]),
            .src    (ent_src[g]),
            .op     (ent_op[g]),
            .size   (ent_size[g])
        );
    end

    logic [CntW-1:0] cnt_nxt;
    assign cnt_nxt = outstanding_o + CntW'(alloc) - CntW'(retire);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outstanding_o <= '0;
            full_o        <= 1'b0;
            empty_o       <= 1'b1;
            err_a_o       <= 1'b0;
            err_d_o       <= 1'b0;
            err_d_code_o  <= 2'd0;
            err_source_o  <= '0;
        end else begin
            outstanding_o <= cnt_nxt;
            full_o        <= (cnt_nxt == CntW'(MaxOut));
            empty_o       <= (cnt_nxt == '0);
            err_a_o       <= a_hs && (a_dup || !a_legal);
            err_d_o       <= d_hs && (d_code != 2'd0);
            err_d_code_o  <= d_hs ? d_code : 2'd0;
            if (d_hs && d_code != 2'd0)
                err_source_o <= d_source_i;
            else if (a_hs && (a_dup || !a_legal))
                err_source_o <= a_source_i;
        end
    end
endmodule

// File: tb/tb_tlul_source_tracker.sv
// Directed bench for tlul_source_tracker with hand-computed expectations.
module tb_tlul_source_tracker;
    logic       clk = 1'b0, rst = 1'b0;
    logic       a_valid = 0, a_ready = 1, a_ready_o;
    logic [2:0] a_opcode = 0;
    logic [1:0] a_size = 0;
    logic [7:0] a_source = 0;
    logic       d_valid = 0, d_ready = 1;
    logic [2:0] d_opcode = 0;
    logic [1:0] d_size = 0;
    logic [7:0] d_source = 0;
    logic [2:0] outstanding;
    logic       full, empty, err_a, err_d;
    logic [1:0] err_code;
    logic [7:0] err_src;
    int total = 0, bad = 0;

    tlul_source_tracker dut (
        .clk_i(clk), .rst_i(rst),
        .a_valid_i(a_valid), .a_ready_i(a_ready), .a_opcode_i(a_opcode),
        .a_size_i(a_size), .a_source_i(a_source), .a_ready_o(a_ready_o),
        .d_valid_i(d_valid), .d_ready_i(d_ready), .d_opcode_i(d_opcode),
        .d_size_i(d_size), .d_source_i(d_source),
        .outstanding_o(outstanding), .full_o(full), .empty_o(empty),
        .err_a_o(err_a), .err_d_o(err_d), .err_d_code_o(err_code),
        .err_source_o(err_src)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        a_valid = 0;
        d_valid = 0;
    endtask

    task automatic drive(input logic av, input logic [2:0] aop, input logic [1:0] asz,
                         input logic [7:0] asrc, input logic dv, input logic [2:0] dop,
                         input logic [1:0] dsz, input logic [7:0] dsrc);
        a_valid = av; a_opcode = aop; a_size = asz; a_source = asrc;
        d_valid = dv; d_opcode = dop; d_size = dsz; d_source = dsrc;
        step();
    endtask

    task automatic a_req(input logic [2:0] op, input logic [1:0] sz, input logic [7:0] src);
        drive(1, op, sz, src, 0, 0, 0, 0);
    endtask

    task automatic d_rsp(input logic [2:0] op, input logic [1:0] sz, input logic [7:0] src);
        drive(0, 0, 0, 0, 1, op, sz, src);
    endtask

    task automatic test_reset();
        rst = 1; step(); step(); rst = 0;
        total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", outstanding); end
        total++; if (empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL reset_flags empty=%b full=%b exp=1/0", empty, full); end
        total++; if ({err_a, err_d, err_code, err_src} !== 12'd0) begin bad++; $display("FAIL reset_err got=%h exp=0", {err_a, err_d, err_code, err_src}); end
    endtask

    task automatic test_basic();
        a_req(3'd4, 2'd2, 8'h05);
        total++; if (outstanding !== 3'd1 || empty !== 1'b0) begin bad++; $display("FAIL basic_alloc cnt=%0d empty=%b exp=1/0", outstanding, empty); end
        d_rsp(3'd1, 2'd2, 8'h05);
        total++; if (outstanding !== 3'd0 || empty !== 1'b1) begin bad++; $display("FAIL basic_retire cnt=%0d empty=%b exp=0/1", outstanding, empty); end
        total++; if (err_a !== 1'b0 || err_d !== 1'b0) begin bad++; $display("FAIL basic_noerr err_a=%b err_d=%b exp=0", err_a, err_d); end
    endtask

    task automatic test_full();
        for (int s = 1; s <= 4; s++) a_req(3'd0, 2'd2, 8'(s));
        total++; if (full !== 1'b1 || outstanding !== 3'd4) begin bad++; $display("FAIL full_flag full=%b cnt=%0d exp=1/4", full, outstanding); end
        a_ready = 1;
        total++; if (a_ready_o !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", a_ready_o); end
        a_req(3'd0, 2'd2, 8'h08);
        total++; if (outstanding !== 3'd4 || err_a !== 1'b0) begin bad++; $display("FAIL full_blocked cnt=%0d err_a=%b exp=4/0", outstanding, err_a); end
        d_rsp(3'd0, 2'd2, 8'h03);
        total++; if (full !== 1'b0 || a_ready_o !== 1'b1 || outstanding !== 3'd3) begin bad++; $display("FAIL full_release full=%b rdy=%b cnt=%0d exp=0/1/3", full, a_ready_o, outstanding); end
        d_rsp(3'd0, 2'd2, 8'h01); d_rsp(3'd0, 2'd2, 8'h02); d_rsp(3'd0, 2'd2, 8'h04);
        total++; if (empty !== 1'b1 || err_d !== 1'b0) begin bad++; $display("FAIL full_drain empty=%b err_d=%b exp=1/0", empty, err_d); end
    endtask

    task automatic test_dup();
        a_req(3'd0, 2'd2, 8'h07);
        a_req(3'd0, 2'd2, 8'h07);
        total++; if (err_a !== 1'b1 || err_src !== 8'h07) begin bad++; $display("FAIL dup_pulse err_a=%b src=%h exp=1/07", err_a, err_src); end
        total++; if (outstanding !== 3'd1) begin bad++; $display("FAIL dup_cnt got=%0d exp=1", outstanding); end
        step();
        total++; if (err_a !== 1'b0) begin bad++; $display("FAIL dup_one_cycle got=%b exp=0", err_a); end
        // A duplicate and D unknown together: D source wins
        drive(1, 3'd0, 2'd2, 8'h07, 1, 3'd0, 2'd0, 8'h30);
        total++; if (err_a !== 1'b1 || err_d !== 1'b1 || err_src !== 8'h30) begin bad++; $display("FAIL dup_both a=%b d=%b src=%h exp=1/1/30", err_a, err_d, err_src); end
        a_req(3'd2, 2'd0, 8'h11);
        total++; if (err_a !== 1'b1 || err_src !== 8'h11 || outstanding !== 3'd1) begin bad++; $display("FAIL illegal_op err_a=%b src=%h cnt=%0d exp=1/11/1", err_a, err_src, outstanding); end
        d_rsp(3'd0, 2'd2, 8'h07);
    endtask

    task automatic test_unknown();
        d_rsp(3'd0, 2'd0, 8'h22);
        total++; if (err_d !== 1'b1 || err_code !== 2'd1 || err_src !== 8'h22) begin bad++; $display("FAIL unknown err_d=%b code=%0d src=%h exp=1/1/22", err_d, err_code, err_src); end
        total++; if (outstanding !== 3'd0 || empty !== 1'b1) begin bad++; $display("FAIL unknown_cnt cnt=%0d empty=%b exp=0/1", outstanding, empty); end
        step();
        total++; if (err_d !== 1'b0 || err_code !== 2'd0) begin bad++; $display("FAIL unknown_clear err_d=%b code=%0d exp=0/0", err_d, err_code); end
    endtask

    task automatic test_mismatch();
        a_req(3'd4, 2'd2, 8'h09);
        d_rsp(3'd0, 2'd2, 8'h09);
        total++; if (err_code !== 2'd2 || err_d !== 1'b1 || outstanding !== 3'd0) begin bad++; $display("FAIL op_mm code=%0d err_d=%b cnt=%0d exp=2/1/0", err_code, err_d, outstanding); end
        a_req(3'd1, 2'd2, 8'h0a);
        d_rsp(3'd0, 2'd1, 8'h0a);
        total++; if (err_code !== 2'd3 || err_src !== 8'h0a || outstanding !== 3'd0) begin bad++; $display("FAIL size_mm code=%0d src=%h cnt=%0d exp=3/0a/0", err_code, err_src, outstanding); end
        a_req(3'd0, 2'd2, 8'h0b);
        d_rsp(3'd1, 2'd0, 8'h0b);
        total++; if (err_code !== 2'd2) begin bad++; $display("FAIL mm_priority code=%0d exp=2", err_code); end
    endtask

    task automatic test_same_cycle();
        a_req(3'd0, 2'd2, 8'h06);
        drive(1, 3'd0, 2'd2, 8'h06, 1, 3'd0, 2'd2, 8'h06);
        total++; if (err_a !== 1'b0 || err_d !== 1'b0 || outstanding !== 3'd1) begin bad++; $display("FAIL same_src err_a=%b err_d=%b cnt=%0d exp=0/0/1", err_a, err_d, outstanding); end
        a_req(3'd0, 2'd2, 8'h01); a_req(3'd0, 2'd2, 8'h02); a_req(3'd0, 2'd2, 8'h03);
        // Full: the retire frees a slot but the A cannot handshake this cycle
        drive(1, 3'd4, 2'd0, 8'h05, 1, 3'd0, 2'd2, 8'h06);
        total++; if (outstanding !== 3'd3 || full !== 1'b0 || err_a !== 1'b0) begin bad++; $display("FAIL same_full cnt=%0d full=%b err_a=%b exp=3/0/0", outstanding, full, err_a); end
    endtask

    task automatic test_reset_mid();
        total++; if (outstanding !== 3'd3) begin bad++; $display("FAIL mid_pre cnt=%0d exp=3", outstanding); end
        rst = 1; step(); rst = 0;
        total++; if (outstanding !== 3'd0 || empty !== 1'b1) begin bad++; $display("FAIL mid_reset cnt=%0d empty=%b exp=0/1", outstanding, empty); end
        d_rsp(3'd0, 2'd2, 8'h01);
        total++; if (err_d !== 1'b1 || err_code !== 2'd1 || outstanding !== 3'd0) begin bad++; $display("FAIL post_reset_rsp err_d=%b code=%0d cnt=%0d exp=1/1/0", err_d, err_code, outstanding); end
    endtask

    initial begin
        #2;
        test_reset();
        test_basic();
        test_full();
        test_dup();
        test_unknown();
        test_mismatch();
        test_same_cycle();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
